// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA command sequencer.
package dma_pkg;

    localparam int unsigned DESC_W_DEFAULT = 97;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_STOPPED = 3'd3,
        ST_ERR     = 3'd4
    } state_e;

    // Direction bit as seen by the DMA engine.
    localparam logic DIR_C2H = 1'b0;
    localparam logic DIR_H2C = 1'b1;

endpackage

// File: rtl/dma_cmd_fifo.sv
// Circular command queue; flush has priority over push and pop.
module dma_cmd_fifo #(
    parameter  int unsigned W     = 98,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CW    = PTR_W + 1
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          i_push,
    input  logic [W-1:0]  i_wdata,
    input  logic          i_pop,
    input  logic          i_flush,
    output logic [W-1:0]  o_rdata,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty
);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wp;
    logic [PTR_W-1:0] r_rp;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rp];

    assign w_push = i_push && !o_full  && !i_flush;
    assign w_pop  = i_pop  && !o_empty && !i_flush;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + PTR_W'(1);
            if (w_pop)  r_rp <= r_rp + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: it is only read behind a non-zero count.
    always_ff @(posedge CLK) begin
        if (w_push) r_mem[r_wp] <= i_wdata;
    end

endmodule

// File: rtl/dma_cmd_sequencer.sv
// Queues ADMA descriptor commands and issues them one at a time to the DMA,
// with stop/resume, error abort with queue flush, and a completion counter.
module dma_cmd_sequencer import dma_pkg::*; #(
    parameter int unsigned DESC_W = DESC_W_DEFAULT,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              push_valid,
    output logic              push_ready,
    input  logic [DESC_W-1:0] push_desc,
    input  logic              push_dir,
    input  logic              start,
    input  logic              stop_req,
    input  logic              clear_err,
    input  logic              dma_done,
    input  logic              dma_error,
    output logic [DESC_W-1:0] address_descriptor,
    output logic              command_reg_write,
    output logic              command_reg_continue,
    output logic              direction,
    output logic              STOP,
    output logic              busy,
    output logic              err,
    output logic [CNT_W-1:0]  done_count
);

    localparam int unsigned FIFO_W = DESC_W + 1;
    localparam int unsigned QCNT_W = $clog2(DEPTH) + 1;

    state_e              r_state;
    state_e              w_next;
    logic                r_stop_pending;
    logic                w_push;
    logic                w_pop;
    logic                w_flush;
    logic                w_done_ok;
    logic                w_full;
    logic                w_empty;
    logic [QCNT_W-1:0]   w_count;
    logic [FIFO_W-1:0]   w_head;

    dma_cmd_fifo #(
        .W     (FIFO_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RESET   (RESET),
        .i_push  (w_push),
        .i_wdata ({push_dir, push_desc}),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_push    = push_valid && push_ready;
    assign w_done_ok = (r_state == ST_WAIT) && dma_done && !dma_error;
    assign w_flush   = (r_state == ST_WAIT) && dma_error;
    // Every entry into ISSUE pops the head, whether from IDLE or straight from WAIT.
    assign w_pop     = (w_next == ST_ISSUE);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (stop_req)                w_next = ST_STOPPED;
                else if (start && !w_empty)  w_next = ST_ISSUE;
            end
            ST_ISSUE: w_next = ST_WAIT;
            ST_WAIT: begin
                if (dma_error) begin
                    w_next = ST_ERR;
                end else if (dma_done) begin
                    if (r_stop_pending || stop_req) w_next = ST_STOPPED;
                    else if (!w_empty)              w_next = ST_ISSUE;
                    else                            w_next = ST_IDLE;
                end
            end
            ST_STOPPED: if (start && !stop_req) w_next = ST_IDLE;
            ST_ERR:     if (clear_err)          w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        command_reg_write = 1'b0;
        busy              = 1'b0;
        STOP              = 1'b0;
        err               = 1'b0;
        push_ready        = !w_full;
        case (r_state)
            ST_ISSUE:   begin command_reg_write = 1'b1; busy = 1'b1; end
            ST_WAIT:    busy = 1'b1;
            ST_STOPPED: STOP = 1'b1;
            ST_ERR:     begin STOP = 1'b1; err = 1'b1; push_ready = 1'b0; end
            default:    ;
        endcase
    end

    // Issue payload, captured from the queue head on the pop edge.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            address_descriptor   <= '0;
            direction            <= DIR_C2H;
            command_reg_continue <= 1'b0;
        end else if (w_pop) begin
            address_descriptor   <= w_head[DESC_W-1:0];
            direction            <= w_head[DESC_W];
            command_reg_continue <= (w_count > QCNT_W'(1));
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            done_count     <= '0;
            r_stop_pending <= 1'b0;
        end else begin
            if (w_done_ok) done_count <= done_count + CNT_W'(1);
            if ((r_state == ST_WAIT) && (dma_done || dma_error))
                r_stop_pending <= 1'b0;
            else if (((r_state == ST_ISSUE) || (r_state == ST_WAIT)) && stop_req)
                r_stop_pending <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dma_cmd_sequencer.sv
// Directed self-checking bench for dma_cmd_sequencer.
module tb_dma_cmd_sequencer;
    import dma_pkg::*;

    localparam int unsigned DESC_W = 97;
    localparam int unsigned CNT_W  = 8;

    logic              CLK;
    logic              RESET;
    logic              push_valid;
    logic              push_ready;
    logic [DESC_W-1:0] push_desc;
    logic              push_dir;
    logic              start;
    logic              stop_req;
    logic              clear_err;
    logic              dma_done;
    logic              dma_error;
    logic [DESC_W-1:0] address_descriptor;
    logic              command_reg_write;
    logic              command_reg_continue;
    logic              direction;
    logic              STOP;
    logic              busy;
    logic              err;
    logic [CNT_W-1:0]  done_count;

    int n_checks = 0;
    int n_errors = 0;

    dma_cmd_sequencer #(.DESC_W(DESC_W), .DEPTH(4), .CNT_W(CNT_W)) dut (
        .CLK                  (CLK),
        .RESET                (RESET),
        .push_valid           (push_valid),
        .push_ready           (push_ready),
        .push_desc            (push_desc),
        .push_dir             (push_dir),
        .start                (start),
        .stop_req             (stop_req),
        .clear_err            (clear_err),
        .dma_done             (dma_done),
        .dma_error            (dma_error),
        .address_descriptor   (address_descriptor),
        .command_reg_write    (command_reg_write),
        .command_reg_continue (command_reg_continue),
        .direction            (direction),
        .STOP                 (STOP),
        .busy                 (busy),
        .err                  (err),
        .done_count           (done_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_cmd(input logic [DESC_W-1:0] d, input logic r);
        push_valid = 1'b1;
        push_desc  = d;
        push_dir   = r;
        tick();
        push_valid = 1'b0;
    endtask

    task automatic pulse_done();
        dma_done = 1'b1;
        tick();
        dma_done = 1'b0;
    endtask

    task automatic start_issue();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic expect_issue(input string tag, input logic [DESC_W-1:0] d,
                                input logic r, input logic c);
        check_eq({tag, "_wr"},   128'(command_reg_write),    128'(1'b1));
        check_eq({tag, "_addr"}, 128'(address_descriptor),   128'(d));
        check_eq({tag, "_dir"},  128'(direction),            128'(r));
        check_eq({tag, "_cont"}, 128'(command_reg_continue), 128'(c));
        check_eq({tag, "_busy"}, 128'(busy),                 128'(1'b1));
    endtask

    task automatic expect_reset_outputs(input string tag);
        check_eq({tag, "_addr"}, 128'(address_descriptor),   128'(0));
        check_eq({tag, "_dir"},  128'(direction),            128'(0));
        check_eq({tag, "_cont"}, 128'(command_reg_continue), 128'(0));
        check_eq({tag, "_wr"},   128'(command_reg_write),    128'(0));
        check_eq({tag, "_stop"}, 128'(STOP),                 128'(0));
        check_eq({tag, "_busy"}, 128'(busy),                 128'(0));
        check_eq({tag, "_err"},  128'(err),                  128'(0));
        check_eq({tag, "_cnt"},  128'(done_count),           128'(0));
    endtask

    logic [DESC_W-1:0] q_desc [4];
    logic              q_dir  [4];

    initial begin
        RESET = 1'b0; push_valid = 1'b0; push_desc = '0; push_dir = 1'b0;
        start = 1'b0; stop_req = 1'b0; clear_err = 1'b0;
        dma_done = 1'b0; dma_error = 1'b0;
        q_desc[0] = 97'h1_0000_0000_0000_0000_0000_00A1; q_dir[0] = DIR_H2C;
        q_desc[1] = 97'h0_DEAD_BEEF_0000_0000_0000_00B2; q_dir[1] = DIR_C2H;
        q_desc[2] = 97'h0_0000_0000_0000_0000_0000_00C3; q_dir[2] = DIR_H2C;
        q_desc[3] = 97'h1_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF; q_dir[3] = DIR_C2H;
        repeat (3) @(posedge CLK);
        #1;
        expect_reset_outputs("rst");
        check_eq("rst_ready", 128'(push_ready), 128'(1));
        RESET = 1'b1;
        tick();

        // Single command
        push_cmd(97'h1234, 1'b1);
        start_issue();
        expect_issue("single", 97'h1234, 1'b1, 1'b0);
        tick();
        check_eq("single_wr_low", 128'(command_reg_write), 128'(0));
        pulse_done();
        check_eq("single_busy", 128'(busy), 128'(0));
        check_eq("single_cnt",  128'(done_count), 128'(1));

        // Back-to-back full queue, fifth push ignored
        for (int i = 0; i < 4; i++) push_cmd(q_desc[i], q_dir[i]);
        check_eq("full_ready", 128'(push_ready), 128'(0));
        push_cmd(97'h5555, 1'b1);
        start_issue();
        expect_issue("b2b0", q_desc[0], q_dir[0], 1'b1);
        for (int i = 1; i < 4; i++) begin
            tick();
            pulse_done();
            expect_issue($sformatf("b2b%0d", i), q_desc[i], q_dir[i], (i < 3) ? 1'b1 : 1'b0);
        end
        tick();
        pulse_done();
        check_eq("b2b_busy", 128'(busy), 128'(0));
        check_eq("b2b_cnt",  128'(done_count), 128'(5));
        check_eq("b2b_ready", 128'(push_ready), 128'(1));
        start_issue();
        check_eq("b2b_empty_wr", 128'(command_reg_write), 128'(0));

        // Simultaneous push/pop, pointers wrap
        push_cmd(97'h100, 1'b0);
        push_cmd(97'h101, 1'b1);
        start_issue();
        expect_issue("pp0", 97'h100, 1'b0, 1'b1);
        push_valid = 1'b1; push_desc = 97'h102; push_dir = 1'b0;
        tick();
        push_desc = 97'h103; push_dir = 1'b1; dma_done = 1'b1;
        tick();
        push_valid = 1'b0; dma_done = 1'b0;
        expect_issue("pp1", 97'h101, 1'b1, 1'b1);
        tick(); pulse_done();
        expect_issue("pp2", 97'h102, 1'b0, 1'b1);
        tick(); pulse_done();
        expect_issue("pp3", 97'h103, 1'b1, 1'b0);
        tick(); pulse_done();
        check_eq("pp_cnt", 128'(done_count), 128'(9));

        // Stop after current descriptor, then resume
        push_cmd(97'hA4, 1'b1);
        push_cmd(97'hB4, 1'b0);
        push_cmd(97'hC4, 1'b1);
        start_issue();
        expect_issue("st_a", 97'hA4, 1'b1, 1'b1);
        tick();
        stop_req = 1'b1; tick(); stop_req = 1'b0;
        check_eq("st_pend_stop", 128'(STOP), 128'(0));
        check_eq("st_pend_busy", 128'(busy), 128'(1));
        pulse_done();
        check_eq("st_stop", 128'(STOP), 128'(1));
        check_eq("st_wr",   128'(command_reg_write), 128'(0));
        check_eq("st_busy", 128'(busy), 128'(0));
        check_eq("st_cnt",  128'(done_count), 128'(10));
        check_eq("st_ready", 128'(push_ready), 128'(1));
        push_cmd(97'hD4, 1'b0);
        check_eq("st_hold", 128'(STOP), 128'(1));
        start = 1'b1;
        tick();
        check_eq("st_resume", 128'(STOP), 128'(0));
        check_eq("st_resume_wr", 128'(command_reg_write), 128'(0));
        tick();
        start = 1'b0;
        expect_issue("st_b", 97'hB4, 1'b0, 1'b1);
        tick(); pulse_done();
        expect_issue("st_c", 97'hC4, 1'b1, 1'b1);
        tick(); pulse_done();
        expect_issue("st_d", 97'hD4, 1'b0, 1'b0);
        tick(); pulse_done();
        check_eq("st_cnt_end", 128'(done_count), 128'(13));

        // Error abort with simultaneous done
        push_cmd(97'hE1, 1'b1);
        push_cmd(97'hE2, 1'b0);
        push_cmd(97'hE3, 1'b1);
        start_issue();
        expect_issue("er_1", 97'hE1, 1'b1, 1'b1);
        tick();
        dma_error = 1'b1; dma_done = 1'b1;
        tick();
        dma_error = 1'b0; dma_done = 1'b0;
        check_eq("er_err",   128'(err), 128'(1));
        check_eq("er_stop",  128'(STOP), 128'(1));
        check_eq("er_busy",  128'(busy), 128'(0));
        check_eq("er_cnt",   128'(done_count), 128'(13));
        check_eq("er_ready", 128'(push_ready), 128'(0));
        push_cmd(97'hEE, 1'b1);
        check_eq("er_hold", 128'(err), 128'(1));
        clear_err = 1'b1; tick(); clear_err = 1'b0;
        check_eq("er_clr_err",   128'(err), 128'(0));
        check_eq("er_clr_stop",  128'(STOP), 128'(0));
        check_eq("er_clr_ready", 128'(push_ready), 128'(1));
        start_issue();
        check_eq("er_flush_wr",   128'(command_reg_write), 128'(0));
        check_eq("er_flush_busy", 128'(busy), 128'(0));

        // Asynchronous reset mid-WAIT with commands queued
        for (int i = 0; i < 4; i++) push_cmd(q_desc[i], q_dir[i]);
        start_issue();
        expect_issue("rm_0", q_desc[0], q_dir[0], 1'b1);
        tick();
        check_eq("rm_wait", 128'(busy), 128'(1));
        #2 RESET = 1'b0;
        #1;
        expect_reset_outputs("rm");
        tick(); tick();
        RESET = 1'b1;
        start = 1'b1;
        tick();
        check_eq("rm_start_wr", 128'(command_reg_write), 128'(0));
        tick();
        check_eq("rm_start_busy", 128'(busy), 128'(0));
        start = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dma_cmd_sequencer.md
Name: dma_cmd_sequencer

Overview:
Parametrised, synthesizable successor to the fixed DMA stimulus source in host_if_ADMA. It queues up to DEPTH ADMA descriptor commands, each a descriptor address plus a direction bit. It issues them one at a time to the DMA engine using address_descriptor, command_reg_write, command_reg_continue and direction, and waits for DMA completion before issuing the next. It adds stop/resume, error abort with queue flush, and a completion counter.

Parameters:
DESC_W, 97, width of address_descriptor (matches the existing [96:0] descriptor bus)
DEPTH, 4, command queue depth; power of two, >=2
CNT_W, 8, width of the completed-descriptor counter; wraps modulo 2^CNT_W

Ports:
CLK  in  1  single clock, rising edge
RESET  in  1  asynchronous, active-low reset (all state cleared while RESET==0)
push_valid  in  1  host offers a command
push_ready  out  1  queue can accept: count<DEPTH and state!=ERR
push_desc  in  DESC_W  descriptor address to queue
push_dir  in  1  direction for the command (1 = host->card, as on the DMA)
start  in  1  level; permits issuing from IDLE, and resumes from STOPPED
stop_req  in  1  single-cycle request to halt after the current descriptor
clear_err  in  1  single-cycle; leaves ERR
dma_done  in  1  single-cycle pulse from the DMA: current descriptor finished
dma_error  in  1  single-cycle pulse from the DMA: current descriptor failed
address_descriptor  out  DESC_W  registered; descriptor being issued
command_reg_write  out  1  one-cycle strobe, high exactly while state==ISSUE
command_reg_continue  out  1  registered; 1 if more commands were queued behind this one at issue
direction  out  1  registered; direction of the issued command
STOP  out  1  high in STOPPED and ERR
busy  out  1  high in ISSUE or WAIT
err  out  1  high in ERR
done_count  out  CNT_W  number of dma_done pulses accepted in WAIT

Behaviour:
- Reset values: state=IDLE, queue empty (count=0, pointers=0), address_descriptor=0, direction=0, command_reg_continue=0, command_reg_write=0, STOP=0, busy=0, err=0, done_count=0, stop_pending=0.
- Queue: circular FIFO with count width clog2(DEPTH)+1.
  - A push is accepted on an edge where push_valid&&push_ready.
  - Pointers wrap at DEPTH.
  - A push and a pop on the same edge leave count unchanged.
  - A push while full is ignored (push_ready=0).
  - A push while in ERR is ignored.
- FSM states:
  - IDLE:
    - stop_req -> STOPPED (stop_req has priority over start).
    - Otherwise start&&count!=0 -> ISSUE. On that edge: pop the head; load address_descriptor and direction; set command_reg_continue=(count>1 before pop).
  - ISSUE: lasts one cycle, command_reg_write=1 -> WAIT.
    - Latency: start sampled at edge N gives command_reg_write high in cycle N+1.
  - WAIT:
    - dma_error -> ERR. dma_error has priority over dma_done on the same cycle; done_count is not incremented.
    - dma_done: done_count+1, then:
      - if stop_pending (or stop_req this cycle) -> STOPPED, clear stop_pending;
      - else if count!=0 -> ISSUE (pop/load as above, no IDLE gap);
      - else -> IDLE.
    - stop_req without done: set stop_pending.
  - STOPPED:
    - STOP=1, queue contents retained, pushes still accepted.
    - start&&!stop_req -> IDLE, STOP clears.
  - ERR:
    - On entry the queue is flushed (count=0, pointers=0). err=1, STOP=1.
    - clear_err -> IDLE.
    - dma_done and dma_error are ignored.
- dma_done and dma_error are ignored outside WAIT.
- stop_req in ISSUE sets stop_pending.
- Outputs address_descriptor and direction hold their last issued values until the next issue.
- RESET asserted mid-operation immediately returns all state to reset values and discards the queue; no partial command strobe.

Decomposition:
- Shared package dma_pkg: state encoding constants (IDLE, ISSUE, WAIT, STOPPED, ERR), default DESC_W=97, direction encoding.
- One sub-module is natural: dma_cmd_fifo (parametrised DESC_W+1 wide, DEPTH deep). It exposes push/pop, count, full, empty and flush.
- The FSM and counters stay in dma_cmd_sequencer.

Test Plan:
- Single command:
  - Reset, push desc=0x1234 dir=1, start=1.
  - command_reg_write high one cycle later.
  - address_descriptor=0x1234, direction=1, command_reg_continue=0, busy=1.
  - dma_done -> IDLE, done_count=1.
- Back-to-back queue:
  - Push 4 descriptors (A..D), push_ready=0 after the 4th; a 5th push is ignored. Start.
  - A,B,C are issued with continue=1 and D with continue=0.
  - Each dma_done leads to the next command_reg_write the following cycle.
  - done_count=4, queue empty.
- Simultaneous push/pop:
  - Push on the same edge as the WAIT->ISSUE pop with count=2; count stays 2.
  - Order preserved across pointer wrap after 6 total commands.
- Stop/resume:
  - stop_req during WAIT of A with B,C queued.
  - On dma_done -> STOPPED, STOP=1, no write strobe.
  - start -> B issued with continue=1.
- Error abort:
  - dma_error and dma_done in the same cycle with 2 commands queued.
  - -> ERR, err=1, STOP=1, queue flushed, done_count unchanged, push_ready=0.
  - clear_err -> IDLE, push_ready=1.
- Reset mid-operation:
  - Drop RESET during WAIT with 3 queued.
  - All outputs return to 0 asynchronously; after release, start issues nothing (queue empty).
